// File: rtl/video_line_fetch.sv
// Scanline prefetch: walks roller RAM, fetches one line of pixel bytes over a
// req/ack memory port into a ping-pong buffer read by the display side.
module video_line_fetch #(
  parameter int BYTES_PER_LINE = 90,
  parameter int ADDR_W         = 17
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              fetch_start,
  input  logic [7:0]        fetch_y,
  input  logic              line_start,
  input  logic [7:0]        roller_ptr,
  input  logic [7:0]        yscroll,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_din,
  input  logic [6:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              underrun,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, ROLL_LO, ROLL_HI, PIXELS} state_t;

  localparam logic [6:0] LAST = 7'(BYTES_PER_LINE - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] roller_base, base_eff;
  logic [ADDR_W-1:0] entry, entry_next;
  logic [ADDR_W-1:0] line_addr, line_addr_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [7:0]        lo, lo_next;
  logic [7:0]        scroll_y;
  logic [6:0]        n, n_next;
  logic              mem_req_next, busy_next;
  logic              wr_buf, wr_buf_next, wr_en;
  logic              front;

  logic [7:0] buf0 [BYTES_PER_LINE];
  logic [7:0] buf1 [BYTES_PER_LINE];

  assign scroll_y = fetch_y + yscroll;
  // A frame_start in the same cycle as fetch_start must already take effect.
  assign base_eff = frame_start ? ADDR_W'({roller_ptr, 9'b0}) : roller_base;

  always_comb begin
    state_next     = state;
    entry_next     = entry;
    line_addr_next = line_addr;
    mem_addr_next  = mem_addr;
    mem_req_next   = mem_req;
    busy_next      = busy;
    lo_next        = lo;
    n_next         = n;
    wr_buf_next    = wr_buf;
    wr_en          = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_start) begin
          entry_next    = base_eff + ADDR_W'({scroll_y, 1'b0});
          mem_addr_next = entry_next;
          mem_req_next  = 1'b1;
          busy_next     = 1'b1;
          // Target whichever buffer is back after any simultaneous swap.
          wr_buf_next   = line_start ? front : ~front;
          state_next    = ROLL_LO;
        end
      end
      ROLL_LO: begin
        if (mem_ack) begin
          lo_next       = mem_din;
          mem_addr_next = entry + ADDR_W'(1);
          state_next    = ROLL_HI;
        end
      end
      ROLL_HI: begin
        if (mem_ack) begin
          line_addr_next = ADDR_W'({mem_din, lo[7:3], 1'b0, lo[2:0]});
          mem_addr_next  = line_addr_next;
          n_next         = 7'd0;
          state_next     = PIXELS;
        end
      end
      PIXELS: begin
        if (mem_ack) begin
          wr_en  = 1'b1;
          n_next = n + 7'd1;
          if (n == LAST) begin
            mem_req_next = 1'b0;
            busy_next    = 1'b0;
            state_next   = IDLE;
          end else begin
            mem_addr_next = line_addr + ADDR_W'({n_next, 3'b000});
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      entry       <= '0;
      line_addr   <= '0;
      mem_addr    <= '0;
      mem_req     <= 1'b0;
      busy        <= 1'b0;
      lo          <= 8'h00;
      n           <= 7'd0;
      wr_buf      <= 1'b0;
      front       <= 1'b0;
      roller_base <= '0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      entry       <= entry_next;
      line_addr   <= line_addr_next;
      mem_addr    <= mem_addr_next;
      mem_req     <= mem_req_next;
      busy        <= busy_next;
      lo          <= lo_next;
      n           <= n_next;
      wr_buf      <= wr_buf_next;
      front       <= front ^ line_start;
      underrun    <= line_start & busy;
      overrun     <= fetch_start & busy;
      if (frame_start)
        roller_base <= ADDR_W'({roller_ptr, 9'b0});
    end
  end

  // Line storage is never reset; it only becomes meaningful after a fetch.
  always_ff @(posedge clk_sys) begin
    if (wr_en && !reset) begin
      if (wr_buf)
        buf1[n] <= mem_din;
      else
        buf0[n] <= mem_din;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      rd_data <= 8'h00;
    else if (rd_addr > LAST)
      rd_data <= 8'h00;
    else
      rd_data <= front ? buf1[rd_addr] : buf0[rd_addr];
  end

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch: entry-address vector table plus
// hand-written sequences for full-line fetch, buffer swap, overrun and reset.
module tb_video_line_fetch;

  localparam int BPL = 90;
  localparam int AW  = 17;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          fetch_start = 1'b0;
  logic [7:0]    fetch_y = 8'h00;
  logic          line_start = 1'b0;
  logic [7:0]    roller_ptr = 8'h00;
  logic [7:0]    yscroll = 8'h00;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_din = 8'h00;
  logic [6:0]    rd_addr = 7'd0;
  logic [7:0]    rd_data;
  logic          busy;
  logic          underrun;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  int            ack_mode = 0;
  int            ack_cnt = 0;
  logic [AW-1:0] lo_addr = '1;
  logic [AW-1:0] hi_addr = '1;
  logic [7:0]    lo_val = 8'h00;
  logic [7:0]    hi_val = 8'h00;
  logic [AW-1:0] addr_log [$];
  int            under_cnt = 0;
  int            over_cnt = 0;

  typedef struct {
    logic          same;
    logic [7:0]    rp;
    logic [7:0]    ys;
    logic [7:0]    fy;
    logic [AW-1:0] exp_entry;
  } vec_t;

  vec_t vecs [6];

  video_line_fetch #(.BYTES_PER_LINE(BPL), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .frame_start(frame_start),
    .fetch_start(fetch_start), .fetch_y(fetch_y), .line_start(line_start),
    .roller_ptr(roller_ptr), .yscroll(yscroll), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_din(mem_din),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    if (a == lo_addr) return lo_val;
    if (a == hi_addr) return hi_val;
    return a[7:0];
  endfunction

  function automatic logic [7:0] exp_byte(input int base, input int idx);
    return 8'((base + 8 * idx) & 255);
  endfunction

  // Memory model: mode 0 never acks, 1 acks every cycle, 3 acks every third.
  always @(negedge clk_sys) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      ack_cnt++;
      if (ack_mode == 1 || (ack_mode == 3 && ack_cnt % 3 == 0)) begin
        mem_ack = 1'b1;
        mem_din = mem_byte(mem_addr);
        addr_log.push_back(mem_addr);
      end
    end else begin
      ack_cnt = 0;
    end
  end

  always @(negedge clk_sys) begin
    if (underrun) under_cnt++;
    if (overrun) over_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic fe, input logic ls,
                               input logic [7:0] fy, input logic [7:0] ys, input logic [7:0] rp);
    frame_start = fs;
    fetch_start = fe;
    line_start  = ls;
    fetch_y     = fy;
    yscroll     = ys;
    roller_ptr  = rp;
    @(negedge clk_sys);
    frame_start = 1'b0;
    fetch_start = 1'b0;
    line_start  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && busy; i++) @(negedge clk_sys);
    checkOutput(name, 32'(busy), 32'd0);
    repeat (2) @(negedge clk_sys);
    ack_mode = 0;
  endtask

  task automatic read_check(input int idx, input logic [7:0] exp, input string name);
    rd_addr = 7'(idx);
    @(negedge clk_sys);
    checkOutput(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int u0;
    int o0;
    vecs[0] = '{1'b1, 8'h12, 8'h00, 8'h03, 17'h02406};
    vecs[1] = '{1'b0, 8'h12, 8'hF0, 8'h20, 17'h02420};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 8'hFF, 17'h001FE};
    vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'hFF, 17'h1FE00};
    vecs[4] = '{1'b1, 8'hFF, 8'h80, 8'h7F, 17'h1FFFE};
    vecs[5] = '{1'b0, 8'hA5, 8'h10, 8'h05, 17'h14A2A};

    repeat (3) @(negedge clk_sys);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset underrun", 32'(underrun), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Entry address table; roller_ptr is perturbed on the fetch cycle when
    // frame_start came earlier, since it must be sampled on frame_start only.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      if (!vecs[i].same) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, vecs[i].rp);
      applyStimulus(vecs[i].same, 1'b1, 1'b0, vecs[i].fy, vecs[i].ys,
                    vecs[i].same ? vecs[i].rp : ~vecs[i].rp);
      checkOutput($sformatf("vec%0d entry", i), 32'(mem_addr), 32'(vecs[i].exp_entry));
      checkOutput($sformatf("vec%0d req", i), 32'(mem_req), 32'd1);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
    end
    do_reset();
    checkOutput("abort req", 32'(mem_req), 32'd0);

    // Roller walk with zero-wait memory.
    lo_addr = 17'h02406; lo_val = 8'h2D;
    hi_addr = 17'h02407; hi_val = 8'h01;
    addr_log.delete();
    ack_mode = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 8'h12);
    wait_idle(200, "A timeout");
    checkOutput("A count", 32'(addr_log.size()), 32'd92);
    if (addr_log.size() == 92) begin
      checkOutput("A addr0", 32'(addr_log[0]), 32'h02406);
      checkOutput("A addr1", 32'(addr_log[1]), 32'h02407);
      checkOutput("A addr2", 32'(addr_log[2]), 32'h00255);
      checkOutput("A addr3", 32'(addr_log[3]), 32'h0025D);
      checkOutput("A addr4", 32'(addr_log[4]), 32'h00265);
      checkOutput("A addr91", 32'(addr_log[91]), 32'h0051D);
    end
    checkOutput("A req low", 32'(mem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Full line, ack every third cycle, default data = address low byte.
    lo_addr = '1; hi_addr = '1;
    addr_log.delete();
    ack_mode = 3;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 8'h00);
    wait_idle(400, "B timeout");
    checkOutput("B count", 32'(addr_log.size()), 32'd92);
    if (addr_log.size() >= 3) checkOutput("B line_addr", 32'(addr_log[2]), 32'h01210);
    read_check(0, exp_byte(32'h55, 0), "A rd0");
    read_check(1, exp_byte(32'h55, 1), "A rd1");
    read_check(89, exp_byte(32'h55, 89), "A rd89");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < BPL; i++) read_check(i, exp_byte(32'h10, i), $sformatf("B rd%0d", i));
    read_check(100, 8'h00, "rd100");
    read_check(127, 8'h00, "rd127");
    checkOutput("no underrun idle", 32'(under_cnt), 32'd0);
    checkOutput("no overrun idle", 32'(over_cnt), 32'd0);

    // Swap and re-request while a fetch is stalled in ROLL_LO.
    addr_log.delete();
    ack_mode = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 8'h00);
    checkOutput("C entry", 32'(mem_addr), 32'h0240A);
    u0 = under_cnt;
    o0 = over_cnt;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 8'h00);
    repeat (3) @(negedge clk_sys);
    checkOutput("C underrun pulses", 32'(under_cnt - u0), 32'd1);
    checkOutput("C overrun pulses", 32'(over_cnt - o0), 32'd1);
    checkOutput("C addr held", 32'(mem_addr), 32'h0240A);
    ack_mode = 1;
    wait_idle(200, "C timeout");
    checkOutput("C count", 32'(addr_log.size()), 32'd92);
    if (addr_log.size() >= 3) begin
      checkOutput("C addr0", 32'(addr_log[0]), 32'h0240A);
      checkOutput("C addr1", 32'(addr_log[1]), 32'h0240B);
      checkOutput("C line_addr", 32'(addr_log[2]), 32'h01612);
    end
    read_check(0, exp_byte(32'h12, 0), "C rd0");
    read_check(89, exp_byte(32'h12, 89), "C rd89");
    u0 = under_cnt;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    read_check(0, exp_byte(32'h10, 0), "B kept rd0");
    read_check(89, exp_byte(32'h10, 89), "B kept rd89");
    checkOutput("idle swap no underrun", 32'(under_cnt - u0), 32'd0);

    // Reset in the middle of PIXELS, then restart from a cleared roller base.
    addr_log.delete();
    ack_mode = 3;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 8'h00);
    for (int i = 0; i < 100 && addr_log.size() < 5; i++) @(negedge clk_sys);
    checkOutput("D reached PIXELS", 32'(addr_log.size() >= 5), 32'd1);
    do_reset();
    checkOutput("D req after reset", 32'(mem_req), 32'd0);
    checkOutput("D busy after reset", 32'(busy), 32'd0);
    ack_mode = 0;
    @(negedge clk_sys);
    addr_log.delete();
    ack_mode = 1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 8'h00);
    wait_idle(200, "D timeout");
    if (addr_log.size() >= 3) begin
      checkOutput("D restart entry", 32'(addr_log[0]), 32'h00006);
      checkOutput("D restart hi", 32'(addr_log[1]), 32'h00007);
      checkOutput("D line_addr", 32'(addr_log[2]), 32'h00E06);
    end else begin
      checkOutput("D restart count", 32'(addr_log.size()), 32'd92);
    end

    // frame_start, line_start and fetch_start together in IDLE.
    lo_addr = 17'h02406; lo_val = 8'h2D;
    hi_addr = 17'h02407; hi_val = 8'h01;
    addr_log.delete();
    u0 = under_cnt;
    ack_mode = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h03, 8'h00, 8'h12);
    wait_idle(200, "E timeout");
    checkOutput("E no underrun", 32'(under_cnt - u0), 32'd0);
    if (addr_log.size() >= 1) checkOutput("E entry", 32'(addr_log[0]), 32'h02406);
    read_check(0, exp_byte(32'h06, 0), "E front kept rd0");
    read_check(89, exp_byte(32'h06, 89), "E front kept rd89");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < BPL; i++) read_check(i, exp_byte(32'h55, i), $sformatf("E rd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
